// File: rtl/count_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_seq_pkg
// Description : Shared types and constants for the count sequence controller.
//               Holds the three-state FSM encoding and the default counter
//               width.
// Revision    : 1.0 - initial release
// ============================================================================
package count_seq_pkg;

  // Default counter / code width in bits.
  localparam int C_DEFAULT_N = 4;

  // Sequence controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : count_seq_pkg
`default_nettype wire

// File: rtl/bin_to_gray_n.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_gray_n
// Description : Parameterised binary-to-Gray encoder, purely combinational.
// Ports       : bin_i  [N-1:0]  binary input
//               gray_o [N-1:0]  Gray code, bin ^ (bin >> 1)
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_gray_n #(
  parameter int N = count_seq_pkg::C_DEFAULT_N
) (
  input  logic [N-1:0] bin_i,
  output logic [N-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule : bin_to_gray_n
`default_nettype wire

// File: rtl/count_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : count_seq_ctrl
// Description : Runs one up/down count sequence of a programmed length from a
//               programmed start value. Provides binary count, its Gray code
//               and a one-hot step-phase ring.
// Ports       : clk        clock, all state on rising edge
//               rst        synchronous active-high reset
//               start_i    launch a sequence (sampled in IDLE only)
//               up_down_i  direction captured with start (1 = up)
//               load_val_i start value captured with start
//               steps_i    number of steps captured with start
//               pause_i    hold sequence state while running
//               abort_i    end a running sequence without done
//               count_o    registered binary count
//               gray_o     Gray code of count_o (combinational)
//               ring_o     one-hot phase, rotates right per executed step
//               busy_o     high whenever not IDLE
//               done_o     one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module count_seq_ctrl #(
  parameter int N = count_seq_pkg::C_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         up_down_i,
  input  logic [N-1:0] load_val_i,
  input  logic [N-1:0] steps_i,
  input  logic         pause_i,
  input  logic         abort_i,
  output logic [N-1:0] count_o,
  output logic [N-1:0] gray_o,
  output logic [N-1:0] ring_o,
  output logic         busy_o,
  output logic         done_o
);

  import count_seq_pkg::*;

  localparam logic [N-1:0] C_ONE = N'(1);

  state_e       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] remaining_q, remaining_d;
  logic [N-1:0] ring_q, ring_d;
  logic         dir_q, dir_d;

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      remaining_q <= '0;
      ring_q      <= C_ONE;
      dir_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      ring_q      <= ring_d;
      dir_q       <= dir_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic. Every register holds unless a branch below
  // explicitly updates it.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    ring_d      = ring_q;
    dir_d       = dir_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          count_d     = load_val_i;
          remaining_d = steps_i;
          dir_d       = up_down_i;
          ring_d      = C_ONE;
          // A zero-length sequence completes immediately.
          state_d     = (steps_i == '0) ? DONE : RUN;
        end
      end

      RUN: begin
        // abort outranks pause; both outrank a step.
        if (abort_i) begin
          state_d = IDLE;
        end else if (!pause_i) begin
          count_d     = dir_q ? (count_q + C_ONE) : (count_q - C_ONE);
          remaining_d = remaining_q - C_ONE;
          ring_d      = {ring_q[0], ring_q[N-1:1]};
          if (remaining_q == C_ONE) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  bin_to_gray_n #(
    .N (N)
  ) u_bin_to_gray (
    .bin_i  (count_q),
    .gray_o (gray_o)
  );

  assign count_o = count_q;
  assign ring_o  = ring_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);

endmodule : count_seq_ctrl
`default_nettype wire

// File: tb/tb_count_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_seq_ctrl
// Description : Directed self-checking bench for count_seq_ctrl (N = 4).
//               Inputs change and outputs are sampled 1 ns after each rising
//               edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_seq_ctrl;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic         up_down_i;
  logic [N-1:0] load_val_i;
  logic [N-1:0] steps_i;
  logic         pause_i;
  logic         abort_i;
  logic [N-1:0] count_o;
  logic [N-1:0] gray_o;
  logic [N-1:0] ring_o;
  logic         busy_o;
  logic         done_o;

  int total;
  int bad;

  count_seq_ctrl #(
    .N (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .up_down_i  (up_down_i),
    .load_val_i (load_val_i),
    .steps_i    (steps_i),
    .pause_i    (pause_i),
    .abort_i    (abort_i),
    .count_o    (count_o),
    .gray_o     (gray_o),
    .ring_o     (ring_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check all visible outputs in one call.
  task automatic chk_all(input string tag, input int cnt, input int gry,
                         input int rng, input int bsy, input int dn);
    chk({tag, ".count"}, int'(count_o), cnt);
    chk({tag, ".gray"},  int'(gray_o),  gry);
    chk({tag, ".ring"},  int'(ring_o),  rng);
    chk({tag, ".busy"},  int'(busy_o),  bsy);
    chk({tag, ".done"},  int'(done_o),  dn);
  endtask

  task automatic launch(input logic ud, input logic [N-1:0] lv, input logic [N-1:0] st);
    start_i    = 1'b1;
    up_down_i  = ud;
    load_val_i = lv;
    steps_i    = st;
    tick();
    // Scramble captured inputs to show they no longer matter.
    start_i    = 1'b0;
    up_down_i  = ~ud;
    load_val_i = ~lv;
    steps_i    = 4'hF;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    start_i    = 1'b1;
    up_down_i  = 1'b1;
    load_val_i = 4'h5;
    steps_i    = 4'h3;
    pause_i    = 1'b0;
    abort_i    = 1'b0;

    // Reset, with start held high: must be ignored.
    tick();
    tick();
    chk_all("rst", 0, 0, 4'b0001, 0, 0);
    rst     = 1'b0;
    start_i = 1'b0;
    tick();
    chk_all("idle", 0, 0, 4'b0001, 0, 0);

    // Up run with wrap: 1110, 1111, 0000, 0001.
    launch(1'b1, 4'b1110, 4'b0011);
    chk_all("up0", 4'b1110, 4'b1001, 4'b0001, 1, 0);
    tick();
    chk_all("up1", 4'b1111, 4'b1000, 4'b1000, 1, 0);
    tick();
    chk_all("up2", 4'b0000, 4'b0000, 4'b0100, 1, 0);
    tick();
    chk_all("up3", 4'b0001, 4'b0001, 4'b0010, 1, 1);
    tick();
    chk_all("up_end", 4'b0001, 4'b0001, 4'b0010, 0, 0);

    // Down run: 0010 -> 0001, 0000, 1111, 1110.
    launch(1'b0, 4'b0010, 4'b0100);
    chk_all("dn0", 4'b0010, 4'b0011, 4'b0001, 1, 0);
    tick();
    chk_all("dn1", 4'b0001, 4'b0001, 4'b1000, 1, 0);
    tick();
    chk_all("dn2", 4'b0000, 4'b0000, 4'b0100, 1, 0);
    tick();
    chk_all("dn3", 4'b1111, 4'b1000, 4'b0010, 1, 0);
    tick();
    chk_all("dn4", 4'b1110, 4'b1001, 4'b0001, 1, 1);
    tick();
    chk_all("dn_end", 4'b1110, 4'b1001, 4'b0001, 0, 0);

    // Pause: hold 0001 for three cycles, then final step with done.
    launch(1'b1, 4'b0000, 4'b0010);
    chk_all("pz0", 4'b0000, 4'b0000, 4'b0001, 1, 0);
    tick();
    chk_all("pz1", 4'b0001, 4'b0001, 4'b1000, 1, 0);
    pause_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("pz_hold", 4'b0001, 4'b0001, 4'b1000, 1, 0);
    end
    pause_i = 1'b0;
    tick();
    chk_all("pz2", 4'b0010, 4'b0011, 4'b0100, 1, 1);
    tick();
    chk_all("pz_end", 4'b0010, 4'b0011, 4'b0100, 0, 0);

    // Zero steps: straight to DONE, no count change afterwards.
    launch(1'b1, 4'b1001, 4'b0000);
    chk_all("z0", 4'b1001, 4'b1101, 4'b0001, 1, 1);
    tick();
    chk_all("z_end", 4'b1001, 4'b1101, 4'b0001, 0, 0);

    // Abort, with an ignored start mid-run.
    launch(1'b1, 4'b0011, 4'b0101);
    chk_all("ab0", 4'b0011, 4'b0010, 4'b0001, 1, 0);
    tick();
    chk_all("ab1", 4'b0100, 4'b0110, 4'b1000, 1, 0);
    start_i    = 1'b1;
    up_down_i  = 1'b0;
    load_val_i = 4'b0000;
    steps_i    = 4'b0001;
    tick();
    chk_all("ab2", 4'b0101, 4'b0111, 4'b0100, 1, 0);
    start_i = 1'b0;
    abort_i = 1'b1;
    pause_i = 1'b1;   // abort must win over pause
    tick();
    chk_all("ab_idle", 4'b0101, 4'b0111, 4'b0100, 0, 0);
    abort_i = 1'b0;
    pause_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("ab_after", 4'b0101, 4'b0111, 4'b0100, 0, 0);
    end

    // Mid-run reset with start asserted.
    launch(1'b1, 4'b1010, 4'b0101);
    tick();
    chk_all("mr_run", 4'b1011, 4'b1110, 4'b1000, 1, 0);
    rst     = 1'b1;
    start_i = 1'b1;
    tick();
    chk_all("mr_rst", 0, 0, 4'b0001, 0, 0);
    tick();
    chk_all("mr_rst2", 0, 0, 4'b0001, 0, 0);
    rst     = 1'b0;
    start_i = 1'b0;
    tick();
    chk_all("mr_idle", 0, 0, 4'b0001, 0, 0);
    launch(1'b1, 4'b0111, 4'b0001);
    chk_all("mr_s0", 4'b0111, 4'b0100, 4'b0001, 1, 0);
    tick();
    chk_all("mr_s1", 4'b1000, 4'b1100, 4'b1000, 1, 1);
    tick();
    chk_all("mr_end", 4'b1000, 4'b1100, 4'b1000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_count_seq_ctrl
`default_nettype wire
